// File: rtl/gold_miner_pkg.sv
// Shared types and default geometry for the gold-miner hook logic.
package gold_miner_pkg;

   typedef enum logic [1:0] {
      ST_SWING   = 2'd0,
      ST_EXTEND  = 2'd1,
      ST_RETRACT = 2'd2,
      ST_SCORE   = 2'd3
   } hook_state_e;

   localparam int DEF_ANG_W   = 5;
   localparam int DEF_ANG_MAX = 16;
   localparam int DEF_LEN_W   = 8;
   localparam int DEF_LEN_MIN = 8;
   localparam int DEF_LEN_MAX = 160;

   // States in which the movement counter may run.
   function automatic logic is_motion_state(hook_state_e s);
      return (s != ST_SCORE);
   endfunction

endpackage

// File: rtl/hook_weight_divider.sv
// Passes every (weight+1)-th tick; heavier objects retract more slowly.
// While clear is high the skip counter is held at zero and no step is emitted.
module hook_weight_divider (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       tick,
   input  logic [1:0] weight,
   output logic       step
);

   logic [1:0] cnt_q, cnt_d;

   // Step on the tick that finds the counter equal to the weight, then wrap.
   always_comb begin
      step  = tick && !clear && (cnt_q == weight);
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 2'd0;
      end else if (tick) begin
         cnt_d = step ? 2'd0 : cnt_q + 2'd1;
      end
   end

   // Skip counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hook_motion_ctrl.sv
// Hook sequencer: swing -> extend -> retract -> score. Steps angle/length on
// movement-counter ticks and gates that counter so it restarts on every state entry.
// Valid/ready note: this block has no handshakes; fire, hit and tick are
// single-cycle strobes sampled on the rising edge, outputs are registered.
module hook_motion_ctrl
   import gold_miner_pkg::*;
#(
   parameter int ANG_W   = DEF_ANG_W,
   parameter int ANG_MAX = DEF_ANG_MAX,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int LEN_MIN = DEF_LEN_MIN,
   parameter int LEN_MAX = DEF_LEN_MAX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       levels,
   input  logic             fire,
   input  logic             tick,
   input  logic             hit,
   input  logic [1:0]       hit_weight,
   input  logic [7:0]       hit_value,
   output logic             counter_en,
   output logic [ANG_W-1:0] angle,
   output logic [LEN_W-1:0] length,
   output logic [1:0]       state,
   output logic             grabbed,
   output logic             score_pulse,
   output logic [7:0]       score_value
);

   localparam logic [ANG_W-1:0] ANG_TOP    = ANG_W'(ANG_MAX);
   localparam logic [ANG_W-1:0] ANG_MID    = ANG_W'(ANG_MAX / 2);
   localparam logic [LEN_W-1:0] LEN_REST   = LEN_W'(LEN_MIN);
   localparam logic [LEN_W-1:0] LEN_REST_P = LEN_W'(LEN_MIN + 1);
   localparam logic [LEN_W-1:0] LEN_TOP    = LEN_W'(LEN_MAX);
   localparam logic [LEN_W-1:0] LEN_TOP_M  = LEN_W'(LEN_MAX - 1);

   hook_state_e      state_q, state_d;
   logic [ANG_W-1:0] angle_q, angle_d;
   logic             dir_up_q, dir_up_d;
   logic [LEN_W-1:0] length_q, length_d;
   logic             grabbed_q, grabbed_d;
   logic [1:0]       weight_q, weight_d;
   logic [7:0]       value_q, value_d;
   logic             counter_en_q, counter_en_d;
   logic             score_pulse_q, score_pulse_d;
   logic [7:0]       score_value_q, score_value_d;

   logic run;
   logic tick_en;
   logic div_step;

   // Paused game (levels==0) freezes everything; ticks count only while the counter is enabled.
   assign run     = (levels != 2'd0);
   assign tick_en = tick && counter_en_q;

   hook_weight_divider u_div (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q != ST_RETRACT),
      .tick   (tick_en),
      .weight (weight_q),
      .step   (div_step)
   );

   // Next-state and datapath update; counter enable drops on any transition.
   always_comb begin
      state_d       = state_q;
      angle_d       = angle_q;
      dir_up_d      = dir_up_q;
      length_d      = length_q;
      grabbed_d     = grabbed_q;
      weight_d      = weight_q;
      value_d       = value_q;
      score_value_d = score_value_q;

      case (state_q)
         ST_SWING: begin
            if (run && fire) begin
               state_d = ST_EXTEND;
            end else if (tick_en) begin
               if (dir_up_q) begin
                  angle_d = angle_q + 1'b1;
                  if (angle_d == ANG_TOP) dir_up_d = 1'b0;
               end else begin
                  angle_d = angle_q - 1'b1;
                  if (angle_d == '0) dir_up_d = 1'b1;
               end
            end
         end
         ST_EXTEND: begin
            if (tick_en && (length_q != LEN_TOP)) length_d = length_q + 1'b1;
            if (run && hit) begin
               state_d   = ST_RETRACT;
               grabbed_d = 1'b1;
               weight_d  = hit_weight;
               value_d   = hit_value;
            end else if (tick_en && (length_q == LEN_TOP_M)) begin
               state_d   = ST_RETRACT;
               grabbed_d = 1'b0;
               weight_d  = 2'd0;
            end
         end
         ST_RETRACT: begin
            if (div_step && (length_q != LEN_REST)) begin
               length_d = length_q - 1'b1;
               if (length_q == LEN_REST_P) state_d = grabbed_q ? ST_SCORE : ST_SWING;
            end
         end
         ST_SCORE: begin
            state_d   = ST_SWING;
            grabbed_d = 1'b0;
            weight_d  = 2'd0;
         end
         default: state_d = ST_SWING;
      endcase

      counter_en_d  = run && is_motion_state(state_d) && (state_d == state_q);
      score_pulse_d = (state_d == ST_SCORE) && (state_q != ST_SCORE);
      if (score_pulse_d) score_value_d = value_q;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_SWING;
         angle_q       <= ANG_MID;
         dir_up_q      <= 1'b1;
         length_q      <= LEN_REST;
         grabbed_q     <= 1'b0;
         weight_q      <= 2'd0;
         value_q       <= 8'd0;
         counter_en_q  <= 1'b0;
         score_pulse_q <= 1'b0;
         score_value_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         angle_q       <= angle_d;
         dir_up_q      <= dir_up_d;
         length_q      <= length_d;
         grabbed_q     <= grabbed_d;
         weight_q      <= weight_d;
         value_q       <= value_d;
         counter_en_q  <= counter_en_d;
         score_pulse_q <= score_pulse_d;
         score_value_q <= score_value_d;
      end
   end

   assign counter_en  = counter_en_q;
   assign angle       = angle_q;
   assign length      = length_q;
   assign state       = state_q;
   assign grabbed     = grabbed_q;
   assign score_pulse = score_pulse_q;
   assign score_value = score_value_q;

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Directed bench for hook_motion_ctrl: inputs driven and outputs sampled on the
// falling edge; awarded score values go through an expected queue.
module tb_hook_motion_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] levels;
   logic       fire;
   logic       tick;
   logic       hit;
   logic [1:0] hit_weight;
   logic [7:0] hit_value;
   logic       counter_en;
   logic [4:0] angle;
   logic [7:0] length;
   logic [1:0] state;
   logic       grabbed;
   logic       score_pulse;
   logic [7:0] score_value;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   logic [4:0] ang_exp_q[$];

   hook_motion_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .levels      (levels),
      .fire        (fire),
      .tick        (tick),
      .hit         (hit),
      .hit_weight  (hit_weight),
      .hit_value   (hit_value),
      .counter_en  (counter_en),
      .angle       (angle),
      .length      (length),
      .state       (state),
      .grabbed     (grabbed),
      .score_pulse (score_pulse),
      .score_value (score_value)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) @(negedge clk);
      tick = 1'b0;
   endtask

   // Score scoreboard: every award strobe must match the next queued value.
   always @(negedge clk) begin : score_mon
      logic [7:0] e;
      if (score_pulse === 1'b1) begin
         tests_run++;
         assert (exp_q.size() != 0) else begin
            tests_failed++;
            $error("FAIL unexpected_score_pulse observed=%0d expected=no_pulse", score_value);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("score_value", 32'(score_value), 32'(e));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] ea;
      reset = 1'b1; levels = 2'd1; fire = 1'b0; tick = 1'b0;
      hit = 1'b0; hit_weight = 2'd0; hit_value = 8'd0;
      cyc(); cyc();
      reset = 1'b0;

      // Reset values
      chk("rst_state", 32'(state), 0);
      chk("rst_angle", 32'(angle), 8);
      chk("rst_length", 32'(length), 8);
      chk("rst_grabbed", 32'(grabbed), 0);
      chk("rst_counter_en", 32'(counter_en), 0);
      chk("rst_score_pulse", 32'(score_pulse), 0);
      chk("rst_score_value", 32'(score_value), 0);
      cyc();
      chk("t1_counter_en_up", 32'(counter_en), 1);

      // T1: 20 swing ticks bounce off ANG_MAX
      for (int a = 9; a <= 16; a++) ang_exp_q.push_back(5'(a));
      for (int a = 15; a >= 4; a--) ang_exp_q.push_back(5'(a));
      tick = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         ea = ang_exp_q.pop_front();
         chk("t1_angle", 32'(angle), 32'(ea));
      end
      tick = 1'b0;
      chk("t1_state", 32'(state), 0);

      // T2: bounce off 0, climb to 12, then fire with a simultaneous tick
      ticks(16);
      chk("t2_angle_pre", 32'(angle), 12);
      fire = 1'b1; tick = 1'b1;
      cyc();
      fire = 1'b0; tick = 1'b0;
      chk("t2_angle_hold", 32'(angle), 12);
      chk("t2_state", 32'(state), 1);
      chk("t2_counter_en_low", 32'(counter_en), 0);
      cyc();
      chk("t2_counter_en_up", 32'(counter_en), 1);

      // T3: full extension without a hit, then empty retract
      ticks(152);
      chk("t3_len_max", 32'(length), 160);
      chk("t3_state_retract", 32'(state), 2);
      chk("t3_grabbed", 32'(grabbed), 0);
      chk("t3_counter_en_low", 32'(counter_en), 0);
      ticks(1);
      chk("t3_tick_ignored", 32'(length), 160);
      chk("t3_counter_en_up", 32'(counter_en), 1);
      ticks(151);
      chk("t3_len_9", 32'(length), 9);
      chk("t3_state_still_retract", 32'(state), 2);
      ticks(1);
      chk("t3_len_rest", 32'(length), 8);
      chk("t3_state_swing", 32'(state), 0);
      chk("t3_angle_kept", 32'(angle), 12);
      cyc();

      // T4: heavy hit at length 40, slow retract, score award
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      chk("t4_state_extend", 32'(state), 1);
      cyc();
      ticks(32);
      chk("t4_len_40", 32'(length), 40);
      hit = 1'b1; hit_weight = 2'd3; hit_value = 8'd50;
      exp_q.push_back(8'd50);
      cyc();
      hit = 1'b0; hit_weight = 2'd0; hit_value = 8'd0;
      chk("t4_state_retract", 32'(state), 2);
      chk("t4_grabbed", 32'(grabbed), 1);
      chk("t4_len_hold", 32'(length), 40);
      cyc();
      tick = 1'b1;
      for (int i = 1; i <= 127; i++) begin
         cyc();
         chk("t4_len_slow", 32'(length), 32'(40 - i / 4));
      end
      cyc();
      tick = 1'b0;
      chk("t4_state_score", 32'(state), 3);
      chk("t4_score_pulse", 32'(score_pulse), 1);
      chk("t4_len_rest", 32'(length), 8);
      cyc();
      chk("t4_state_swing", 32'(state), 0);
      chk("t4_pulse_done", 32'(score_pulse), 0);
      chk("t4_grabbed_clr", 32'(grabbed), 0);
      chk("t4_angle_kept", 32'(angle), 12);
      chk("t4_queue_empty", 32'(exp_q.size()), 0);

      // T5: hit together with the max-length tick
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      cyc();
      ticks(151);
      chk("t5_len_159", 32'(length), 159);
      tick = 1'b1; hit = 1'b1; hit_weight = 2'd2; hit_value = 8'd77;
      cyc();
      tick = 1'b0; hit = 1'b0; hit_weight = 2'd0; hit_value = 8'd0;
      chk("t5_len_160", 32'(length), 160);
      chk("t5_state_retract", 32'(state), 2);
      chk("t5_grabbed", 32'(grabbed), 1);
      cyc();
      ticks(2);
      chk("t5_weight_skip", 32'(length), 160);
      ticks(1);
      chk("t5_weight_step", 32'(length), 159);

      // Reset in RETRACT
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rr_state", 32'(state), 0);
      chk("rr_angle", 32'(angle), 8);
      chk("rr_length", 32'(length), 8);
      chk("rr_grabbed", 32'(grabbed), 0);
      chk("rr_score_pulse", 32'(score_pulse), 0);
      cyc();

      // T6: pause while extending
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      cyc();
      ticks(5);
      chk("t6_len_13", 32'(length), 13);
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      chk("t6_fire_ignored", 32'(state), 1);
      levels = 2'd0;
      cyc();
      chk("t6_counter_en_off", 32'(counter_en), 0);
      ticks(5);
      chk("t6_len_frozen", 32'(length), 13);
      chk("t6_state_hold", 32'(state), 1);
      chk("t6_counter_en_still_off", 32'(counter_en), 0);
      levels = 2'd2;
      cyc();
      chk("t6_counter_en_resume", 32'(counter_en), 1);
      ticks(1);
      chk("t6_len_14", 32'(length), 14);

      cyc();
      chk("end_queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
